// File: rtl/output_mode_sequencer.sv
// output_mode_sequencer
//   Owns the select controls of the shared digital output port. Arbitrates
//   between the DFE datapath and the ADC TEG capture path. A guard interval,
//   with both enables low, separates every hand-over. When both paths request,
//   ownership alternates round-robin after a minimum dwell time.
//
// Ports
//   CLK            : system clock
//   RST            : synchronous, active-high reset
//   REQ_DFE        : level request from the DFE path
//   REQ_ADC_TEG    : level request from the ADC TEG path
//   ENABLE_DFE     : registered one-hot enable for the DFE source
//   ENABLE_ADC_TEG : registered one-hot enable for the ADC TEG source
//   MODE           : registered state (00 IDLE, 01 DFE, 10 ADC, 11 GUARD)
//   BUSY           : high while MODE is GUARD
//   SWITCH_COUNT   : count of entries into DFE or ADC, wraps at 16 bits
module output_mode_sequencer #(
  parameter int unsigned GUARD_CYCLES = 8,
  parameter int unsigned DWELL_MIN    = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_DFE,
  input  logic        REQ_ADC_TEG,
  output logic        ENABLE_DFE,
  output logic        ENABLE_ADC_TEG,
  output logic [1:0]  MODE,
  output logic        BUSY,
  output logic [15:0] SWITCH_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DFE   = 2'b01,
    S_ADC   = 2'b10,
    S_GUARD = 2'b11
  } state_e;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_MIN - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_adc_q, last_adc_d;   // 1: ADC was served last
  logic [15:0] dcnt_q, dcnt_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [15:0] switch_count_q, switch_count_d;
  logic        enable_dfe_q, enable_dfe_d;
  logic        enable_adc_teg_q, enable_adc_teg_d;
  logic        busy_q, busy_d;

  // Round-robin pick: DFE wins unless ADC is also requesting and DFE was last.
  function automatic state_e arb(input logic req_dfe, input logic req_adc,
                                 input logic last_adc);
    if (req_dfe && (!req_adc || last_adc)) return S_DFE;
    else if (req_adc)                      return S_ADC;
    else                                   return S_IDLE;
  endfunction

  always_comb begin
    state_d          = state_q;
    last_adc_d       = last_adc_q;
    dcnt_d           = dcnt_q;
    gcnt_d           = gcnt_q;
    switch_count_d   = switch_count_q;

    case (state_q)
      S_IDLE: state_d = arb(REQ_DFE, REQ_ADC_TEG, last_adc_q);
      S_DFE: begin
        if (!REQ_DFE || (REQ_ADC_TEG && dcnt_q == DWELL_LAST)) begin
          state_d    = S_GUARD;
          last_adc_d = 1'b0;
        end else if (dcnt_q != DWELL_LAST) begin
          dcnt_d = dcnt_q + 16'd1;
        end
      end
      S_ADC: begin
        if (!REQ_ADC_TEG || (REQ_DFE && dcnt_q == DWELL_LAST)) begin
          state_d    = S_GUARD;
          last_adc_d = 1'b1;
        end else if (dcnt_q != DWELL_LAST) begin
          dcnt_d = dcnt_q + 16'd1;
        end
      end
      default: begin
        if (gcnt_q == GUARD_LAST) state_d = arb(REQ_DFE, REQ_ADC_TEG, last_adc_q);
        else                      gcnt_d  = gcnt_q + 8'd1;
      end
    endcase

    // Counters restart on state entry; a grant is any entry into DFE or ADC.
    if (state_d != state_q) begin
      if (state_d == S_DFE || state_d == S_ADC) begin
        dcnt_d         = '0;
        switch_count_d = switch_count_q + 16'd1;
      end
      if (state_d == S_GUARD) gcnt_d = '0;
    end

    enable_dfe_d     = (state_d == S_DFE);
    enable_adc_teg_d = (state_d == S_ADC);
    busy_d           = (state_d == S_GUARD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= S_IDLE;
      last_adc_q       <= 1'b1;
      dcnt_q           <= '0;
      gcnt_q           <= '0;
      switch_count_q   <= '0;
      enable_dfe_q     <= 1'b0;
      enable_adc_teg_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_adc_q       <= last_adc_d;
      dcnt_q           <= dcnt_d;
      gcnt_q           <= gcnt_d;
      switch_count_q   <= switch_count_d;
      enable_dfe_q     <= enable_dfe_d;
      enable_adc_teg_q <= enable_adc_teg_d;
      busy_q           <= busy_d;
    end
  end

  assign ENABLE_DFE     = enable_dfe_q;
  assign ENABLE_ADC_TEG = enable_adc_teg_q;
  assign MODE           = state_q;
  assign BUSY           = busy_q;
  assign SWITCH_COUNT   = switch_count_q;

endmodule
